// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The build option ARB_DROP_EN is consumed by rr_arb_n, not here.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Widest requester vector that onehot_of() can produce; callers truncate to N.
  localparam int unsigned ARB_MAX_N = 64;

  // Reset pointer: N-1, so that the first arbitration after reset behaves
  // exactly like a plain MSB-first priority encoder.
  function automatic int unsigned arb_rst_ptr(input int unsigned n);
    return n - 1;
  endfunction

  function automatic logic [ARB_MAX_N-1:0] onehot_of(input int unsigned idx);
    return ARB_MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational rotating MSB-first priority encoder.
// Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
module rr_pick_n
  import arb_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] pick
);

  logic [W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    pick = '0;
    cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = W'((32'(ptr) + N - k) % N);
      if (!any && req[cand]) begin
        any  = 1'b1;
        pick = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb_n.sv
// N-requester round-robin arbiter with registered grant and grant/ack handshake.
// Define ARB_DROP_EN to withdraw an unacknowledged grant whose request has dropped.
module rr_arb_n
  import arb_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  localparam int unsigned ARB_RST_PTR = arb_rst_ptr(N);

  arb_state_t   state_q, state_nxt;
  logic [W-1:0] ptr_q, ptr_nxt;
  logic         valid_nxt;
  logic [W-1:0] idx_nxt;
  logic [N-1:0] onehot_nxt;

  logic         accept_c;
  logic [W-1:0] ptr_dec_c;
  logic [W-1:0] pick_ptr_c;
  logic         any_c;
  logic [W-1:0] pick_c;
  logic         rearb;

  // Accepting a grant makes the granted requester lowest priority immediately.
  assign accept_c   = (state_q == ARB_GRANT) && ack;
  assign ptr_dec_c  = (gnt_idx == '0) ? W'(ARB_RST_PTR) : gnt_idx - W'(1);
  assign pick_ptr_c = accept_c ? ptr_dec_c : ptr_q;

  rr_pick_n #(.N(N)) u_pick (
    .req  (req),
    .ptr  (pick_ptr_c),
    .any  (any_c),
    .pick (pick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= W'(ARB_RST_PTR);
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      state_q    <= state_nxt;
      ptr_q      <= ptr_nxt;
      gnt_valid  <= valid_nxt;
      gnt_idx    <= idx_nxt;
      gnt_onehot <= onehot_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    ptr_nxt    = ptr_q;
    valid_nxt  = gnt_valid;
    idx_nxt    = gnt_idx;
    onehot_nxt = gnt_onehot;
    rearb      = 1'b0;

    case (state_q)
      ARB_IDLE: rearb = 1'b1;
      ARB_GRANT: begin
        if (ack) begin
          ptr_nxt = ptr_dec_c;
          rearb   = 1'b1;
        end
`ifdef ARB_DROP_EN
        else if (!req[gnt_idx]) begin
          rearb = 1'b1;
        end
`endif
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      if (any_c) begin
        state_nxt  = ARB_GRANT;
        valid_nxt  = 1'b1;
        idx_nxt    = pick_c;
        onehot_nxt = N'(onehot_of(32'(pick_c)));
      end else begin
        state_nxt  = ARB_IDLE;
        valid_nxt  = 1'b0;
        idx_nxt    = '0;
        onehot_nxt = '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_n.sv
// Directed, table-driven bench for rr_arb_n with N=4.
// Follows ARB_DROP_EN so the drop-request vectors match the build.
module tb_rr_arb_n;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         ack;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;

  rr_arb_n #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic [N-1:0] req;
    logic         ack;
    logic         exp_valid;
    logic [W-1:0] exp_idx;
    logic [N-1:0] exp_onehot;
    logic         chk_idx;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_miss;

  task automatic add(input string name, input logic r, input logic [N-1:0] rq,
                     input logic a, input logic v, input logic [W-1:0] idx,
                     input logic [N-1:0] oh, input logic ci);
    vec_t t;
    t.name = name; t.rst = r; t.req = rq; t.ack = a;
    t.exp_valid = v; t.exp_idx = idx; t.exp_onehot = oh; t.chk_idx = ci;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic v, input logic [W-1:0] idx,
                       input logic [N-1:0] oh, input logic ci);
    n_vec++;
    if (gnt_valid !== v || gnt_onehot !== oh || (ci && gnt_idx !== idx) ||
        $countones(gnt_onehot) > 1) begin
      n_miss++;
      $display("FAIL %s: got valid=%b idx=%0d onehot=%b, want valid=%b idx=%0d onehot=%b",
               name, gnt_valid, gnt_idx, gnt_onehot, v, idx, oh);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic a);
    rst = r; req = rq; ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b1; req = '0; ack = 1'b0;

    // reset and idle
    add("rst",     1, 4'b0000, 0, 0, 0, 4'b0000, 1);
    for (int i = 0; i < 4; i++)
      add("idle",  0, 4'b0000, 0, 0, 0, 4'b0000, 1);
    // MSB-first first grant, then held without ack
    add("first",   0, 4'b1011, 0, 1, 3, 4'b1000, 1);
    for (int i = 0; i < 3; i++)
      add("hold",  0, 4'b1011, 0, 1, 3, 4'b1000, 1);
    add("rot1",    0, 4'b1011, 1, 1, 1, 4'b0010, 1);
    add("rot0",    0, 4'b1011, 1, 1, 0, 4'b0001, 1);
    add("rotwrap", 0, 4'b1011, 1, 1, 3, 4'b1000, 1);
    // back-to-back with all requesting: 3 -> 2,1,0,3,2
    add("b2b2",    0, 4'b1111, 1, 1, 2, 4'b0100, 1);
    add("b2b1",    0, 4'b1111, 1, 1, 1, 4'b0010, 1);
    add("b2b0",    0, 4'b1111, 1, 1, 0, 4'b0001, 1);
    add("b2b3",    0, 4'b1111, 1, 1, 3, 4'b1000, 1);
    add("b2b2b",   0, 4'b1111, 1, 1, 2, 4'b0100, 1);
    // reset mid-grant restores ptr=3
    add("pre_rst", 0, 4'b0010, 1, 1, 1, 4'b0010, 1);
    add("midrst",  1, 4'b0011, 0, 0, 0, 4'b0000, 1);
    add("postrst", 0, 4'b0011, 0, 1, 1, 4'b0010, 1);
    // accept with nothing pending goes idle; ptr now 1
    add("get2",    0, 4'b0100, 1, 1, 2, 4'b0100, 1);
    add("toidle",  0, 4'b0000, 1, 0, 0, 4'b0000, 0);
    add("ackidle", 0, 4'b0000, 1, 0, 0, 4'b0000, 0);
    add("regrant", 0, 4'b0100, 0, 1, 2, 4'b0100, 1);
    add("ptr1",    0, 4'b1111, 1, 1, 1, 4'b0010, 1);
    // request drop while granted idx 2 (ptr 0 after this accept)
    add("get2b",   0, 4'b0100, 1, 1, 2, 4'b0100, 1);
`ifdef ARB_DROP_EN
    add("drop",    0, 4'b0001, 0, 1, 0, 4'b0001, 1);
    add("drop2",   0, 4'b0001, 0, 1, 0, 4'b0001, 1);
`else
    add("lock",    0, 4'b0001, 0, 1, 2, 4'b0100, 1);
    add("lock2",   0, 4'b0001, 0, 1, 2, 4'b0100, 1);
`endif
    add("dropack", 0, 4'b0001, 1, 1, 0, 4'b0001, 1);
    // ack wins over drop: ptr -> 3, pick 1
    add("ackwin",  0, 4'b0010, 1, 1, 1, 4'b0010, 1);
    add("selfre",  0, 4'b0010, 1, 1, 1, 4'b0010, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].ack);
      check(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_idx,
            vecs[i].exp_onehot, vecs[i].chk_idx);
    end

    // Hand sequence: grant held while other requests churn, then wrap from ptr=0.
    step(1, 4'b0000, 0);
    check("hs_rst", 0, 0, 4'b0000, 1);
    step(0, 4'b0001, 0);
    check("hs_g0", 1, 0, 4'b0001, 1);
    step(0, 4'b1111, 0);
    check("hs_hold_a", 1, 0, 4'b0001, 1);
    step(0, 4'b0110, 0);
`ifdef ARB_DROP_EN
    check("hs_hold_b", 1, 2, 4'b0100, 1);
`else
    check("hs_hold_b", 1, 0, 4'b0001, 1);
    step(0, 4'b1001, 1);
    check("hs_wrap", 1, 3, 4'b1000, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
